vdp_port_if: RTL and testbench

CPU-side register and port interface of the MSX VDP, sitting directly upstream of the `video` block. Decodes the two VDP I/O ports (data port 0x98, control port 0x99), holds VDP registers R0–R7, and drives the table addresses, mode and colour controls that `video` consumes. Owns the VRAM auto-increment address, read-ahead buffer and VRAM access strobes on the CPU port. Latches status flags from `video` and raises the CPU interrupt.

---
 rtl/vdp_pkg.sv | 31 +++
 rtl/vdp_vram_prefetch.sv | 74 +++++++
 rtl/vdp_port_if.sv | 196 +++++++++++++++++++
 tb/tb_vdp_port_if.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU port interface: register indices,
// display-mode encoding, status-byte bit positions and the prefetch FSM states.
package vdp_pkg;

  localparam logic [2:0] RegR0 = 3'd0;
  localparam logic [2:0] RegR1 = 3'd1;
  localparam logic [2:0] RegR2 = 3'd2;
  localparam logic [2:0] RegR3 = 3'd3;
  localparam logic [2:0] RegR4 = 3'd4;
  localparam logic [2:0] RegR5 = 3'd5;
  localparam logic [2:0] RegR6 = 3'd6;
  localparam logic [2:0] RegR7 = 3'd7;

  typedef enum logic [1:0] {
    ModeText  = 2'd0,
    ModeGfx1  = 2'd1,
    ModeGfx2  = 2'd2,
    ModeMulti = 2'd3
  } vdp_mode_e;

  localparam int unsigned StatF  = 7;
  localparam int unsigned Stat5S = 6;
  localparam int unsigned StatC  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture
  } pf_state_e;

endpackage

// File: rtl/vdp_vram_prefetch.sv
// VRAM address counter, read-ahead buffer and the single-read prefetch FSM
// serving the CPU data port.
module vdp_vram_prefetch
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              cancel_i,
  input  logic              addr_load_i,
  input  logic [ADDR_W-1:0] addr_val_i,
  input  logic              wr_commit_i,
  input  logic [7:0]        wr_data_i,
  input  logic [7:0]        vram_din_i,
  output logic              vram_rd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        read_buf_o
);

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        buf_q, buf_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    vram_rd_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        vram_rd_o = 1'b1;
        state_d   = StCapture;
      end
      StCapture: begin
        buf_d   = vram_din_i;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A data write discards whatever the prefetch was doing.
    if (cancel_i) begin
      state_d = StIdle;
      addr_d  = addr_q;
      buf_d   = buf_q;
    end
    if (wr_commit_i) begin
      addr_d = addr_q + ADDR_W'(1);
      buf_d  = wr_data_i;
    end
    if (addr_load_i) addr_d = addr_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  assign addr_o     = addr_q;
  assign read_buf_o = buf_q;

endmodule

// File: rtl/vdp_port_if.sv
// MSX VDP CPU port decode, registers R0-R7, status flags and interrupt.
// Define VDP_IRQ_EN to drive n_int_o from F & R1[5]; otherwise n_int_o is tied high.
module vdp_port_if
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_port_i,
  input  logic [7:0]        cpu_din_i,
  input  logic              cpu_wr_i,
  input  logic              cpu_rd_i,
  output logic [7:0]        cpu_dout_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [7:0]        vram_dout_o,
  output logic              vram_wr_o,
  output logic              vram_rd_o,
  input  logic [7:0]        vram_din_i,
  output logic [1:0]        mode_o,
  output logic              video_on_o,
  output logic              vert_retrace_int_o,
  output logic              sprite_large_o,
  output logic              sprite_enlarged_o,
  output logic [ADDR_W-1:0] name_table_addr_o,
  output logic [ADDR_W-1:0] color_table_addr_o,
  output logic [ADDR_W-1:0] font_addr_o,
  output logic [ADDR_W-1:0] sprite_attr_addr_o,
  output logic [ADDR_W-1:0] sprite_pattern_table_addr_o,
  output logic [3:0]        text_color_o,
  output logic [3:0]        back_color_o,
  input  logic              interrupt_flag_i,
  input  logic              sprite_collision_i,
  input  logic              too_many_sprites_i,
  input  logic [4:0]        sprite5_i,
  output logic              n_int_o
);

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic       toggle_q, toggle_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] cpu_dout_q, cpu_dout_d;
  logic       wr_pend_q;
  logic [7:0] wdata_q;
  logic       f_q, f_d, c_q, c_d, s5_q, s5_d, tms_q;
  logic [4:0] fifth_q, fifth_d;

  logic       ctrl_wr, data_wr, data_rd, stat_rd;
  logic       addr_load, pf_start, s5_rise;
  logic [7:0] status, read_buf;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
  vdp_mode_e  mode;
  logic       is_gfx2;

  assign ctrl_wr = cpu_wr_i & cpu_port_i;
  assign data_wr = cpu_wr_i & ~cpu_port_i;
  assign data_rd = cpu_rd_i & ~cpu_port_i;
  assign stat_rd = cpu_rd_i & cpu_port_i;

  always_comb begin
    status         = '0;
    status[StatF]  = f_q;
    status[Stat5S] = s5_q;
    status[StatC]  = c_q;
    status[4:0]    = s5_q ? fifth_q : sprite5_i;
  end

  always_comb begin
    toggle_d   = toggle_q;
    latch_d    = latch_q;
    cpu_dout_d = cpu_dout_q;
    regs_d     = regs_q;
    addr_load  = 1'b0;
    pf_start   = 1'b0;
    if (ctrl_wr) begin
      if (!toggle_q) begin
        latch_d  = cpu_din_i;
        toggle_d = 1'b1;
      end else begin
        toggle_d = 1'b0;
        if (cpu_din_i[7]) regs_d[cpu_din_i[2:0]] = latch_q;
        else addr_load = 1'b1;
        pf_start = (cpu_din_i[7:6] == 2'b00);
      end
    end
    if (data_wr) toggle_d = 1'b0;
    if (data_rd) begin
      cpu_dout_d = read_buf;
      toggle_d   = 1'b0;
      pf_start   = 1'b1;
    end
    if (stat_rd) begin
      cpu_dout_d = status;
      toggle_d   = 1'b0;
    end
  end

  // Sources set the flags after the status-read clear, so a same-cycle set survives.
  assign s5_rise = too_many_sprites_i & ~tms_q & ~s5_q;
  assign f_d     = interrupt_flag_i | (f_q & ~stat_rd);
  assign c_d     = sprite_collision_i | (c_q & ~stat_rd);
  assign s5_d    = s5_rise | (s5_q & ~stat_rd);
  assign fifth_d = s5_rise ? sprite5_i : fifth_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q     <= '{default: '0};
      toggle_q   <= 1'b0;
      latch_q    <= '0;
      cpu_dout_q <= '0;
      wr_pend_q  <= 1'b0;
      wdata_q    <= '0;
      f_q        <= 1'b0;
      c_q        <= 1'b0;
      s5_q       <= 1'b0;
      tms_q      <= 1'b0;
      fifth_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      toggle_q   <= toggle_d;
      latch_q    <= latch_d;
      cpu_dout_q <= cpu_dout_d;
      wr_pend_q  <= data_wr;
      if (data_wr) wdata_q <= cpu_din_i;
      f_q        <= f_d;
      c_q        <= c_d;
      s5_q       <= s5_d;
      tms_q      <= too_many_sprites_i;
      fifth_q    <= fifth_d;
    end
  end

  vdp_vram_prefetch #(
    .ADDR_W(ADDR_W)
  ) u_prefetch (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (pf_start),
    .cancel_i    (data_wr),
    .addr_load_i (addr_load),
    .addr_val_i  (ADDR_W'({cpu_din_i[5:0], latch_q})),
    .wr_commit_i (wr_pend_q),
    .wr_data_i   (wdata_q),
    .vram_din_i  (vram_din_i),
    .vram_rd_o   (vram_rd_o),
    .addr_o      (vram_addr_o),
    .read_buf_o  (read_buf)
  );

  assign cpu_dout_o  = cpu_dout_q;
  assign vram_wr_o   = wr_pend_q;
  assign vram_dout_o = wdata_q;

  assign r0 = regs_q[RegR0];
  assign r1 = regs_q[RegR1];
  assign r2 = regs_q[RegR2];
  assign r3 = regs_q[RegR3];
  assign r4 = regs_q[RegR4];
  assign r5 = regs_q[RegR5];
  assign r6 = regs_q[RegR6];
  assign r7 = regs_q[RegR7];

  always_comb begin
    if (r1[4])      mode = ModeText;
    else if (r1[3]) mode = ModeMulti;
    else if (r0[1]) mode = ModeGfx2;
    else            mode = ModeGfx1;
  end

  assign is_gfx2            = (mode == ModeGfx2);
  assign mode_o             = mode;
  assign video_on_o         = r1[6];
  assign vert_retrace_int_o = r1[5];
  assign sprite_large_o     = r1[1];
  assign sprite_enlarged_o  = r1[0];

  assign name_table_addr_o           = ADDR_W'({r2[3:0], 10'b0});
  assign sprite_attr_addr_o          = ADDR_W'({r5[6:0], 7'b0});
  assign sprite_pattern_table_addr_o = ADDR_W'({r6[2:0], 11'b0});
  // Graphics 2 uses only the top bit of R3/R4 as a bank select.
  assign color_table_addr_o = is_gfx2 ? ADDR_W'({r3[7], 13'b0}) : ADDR_W'({r3, 6'b0});
  assign font_addr_o        = is_gfx2 ? ADDR_W'({r4[2], 13'b0}) : ADDR_W'({r4[2:0], 11'b0});
  assign text_color_o       = r7[7:4];
  assign back_color_o       = r7[3:0];

`ifdef VDP_IRQ_EN
  assign n_int_o = ~(f_q & r1[5]);
`else
  assign n_int_o = 1'b1;
`endif

  logic unused_regs;
  assign unused_regs = ^{r0[7:2], r0[0], r1[7], r1[2], r2[7:4], r4[7:3], r5[7], r6[7:3]};

endmodule

// File: tb/tb_vdp_port_if.sv
// Directed bench for vdp_port_if: register table vectors plus hand sequences for
// VRAM write/read timing, status flags, interrupt, toggle reset and reset abort.
module tb_vdp_port_if;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_port = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_din = '0;
  logic [1:0]  mode;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [13:0] name_addr, color_addr, font_addr, sattr_addr, spat_addr;
  logic [3:0]  text_color, back_color;
  logic        interrupt_flag = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = '0;
  logic        n_int;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [16384];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_wr) mem[vram_addr] <= vram_dout;
    if (vram_rd) vram_din <= mem[vram_addr];
  end

  vdp_port_if #(
    .ADDR_W(14)
  ) dut (
    .clk_i                       (clk),
    .reset_i                     (reset),
    .cpu_port_i                  (cpu_port),
    .cpu_din_i                   (cpu_din),
    .cpu_wr_i                    (cpu_wr),
    .cpu_rd_i                    (cpu_rd),
    .cpu_dout_o                  (cpu_dout),
    .vram_addr_o                 (vram_addr),
    .vram_dout_o                 (vram_dout),
    .vram_wr_o                   (vram_wr),
    .vram_rd_o                   (vram_rd),
    .vram_din_i                  (vram_din),
    .mode_o                      (mode),
    .video_on_o                  (video_on),
    .vert_retrace_int_o          (vert_retrace_int),
    .sprite_large_o              (sprite_large),
    .sprite_enlarged_o           (sprite_enlarged),
    .name_table_addr_o           (name_addr),
    .color_table_addr_o          (color_addr),
    .font_addr_o                 (font_addr),
    .sprite_attr_addr_o          (sattr_addr),
    .sprite_pattern_table_addr_o (spat_addr),
    .text_color_o                (text_color),
    .back_color_o                (back_color),
    .interrupt_flag_i            (interrupt_flag),
    .sprite_collision_i          (sprite_collision),
    .too_many_sprites_i          (too_many_sprites),
    .sprite5_i                   (sprite5),
    .n_int_o                     (n_int)
  );

  typedef struct packed {
    logic [7:0]  val;
    logic [2:0]  idx;
    logic [1:0]  exp_mode;
    logic [13:0] exp_name;
    logic [13:0] exp_color;
    logic [13:0] exp_font;
    logic [13:0] exp_sattr;
    logic [13:0] exp_spat;
    logic [7:0]  exp_colors;
    logic [3:0]  exp_ctl;  // {video_on, vert_retrace_int, sprite_large, sprite_enlarged}
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

`ifdef VDP_IRQ_EN
  localparam logic IrqLow = 1'b0;
`else
  localparam logic IrqLow = 1'b1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe held across one rising edge; returns at the falling edge one cycle later.
  task automatic strobe(input logic port, input logic wr, input logic [7:0] d);
    @(negedge clk);
    cpu_port = port;
    cpu_din  = d;
    cpu_wr   = wr;
    cpu_rd   = !wr;
    @(negedge clk);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic op(input logic port, input logic wr, input logic [7:0] d);
    strobe(port, wr, d);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{8'h06, 3'd2, 2'd1, 14'h1800, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 8'h00, 4'h0};
    vecs[1]  = '{8'h02, 3'd0, 2'd2, 14'h1800, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 8'h00, 4'h0};
    vecs[2]  = '{8'h07, 3'd4, 2'd2, 14'h1800, 14'h0000, 14'h2000, 14'h0000, 14'h0000, 8'h00, 4'h0};
    vecs[3]  = '{8'hFF, 3'd3, 2'd2, 14'h1800, 14'h2000, 14'h2000, 14'h0000, 14'h0000, 8'h00, 4'h0};
    vecs[4]  = '{8'h00, 3'd0, 2'd1, 14'h1800, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00, 4'h0};
    vecs[5]  = '{8'h7F, 3'd5, 2'd1, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h0000, 8'h00, 4'h0};
    vecs[6]  = '{8'h05, 3'd6, 2'd1, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'h00, 4'h0};
    vecs[7]  = '{8'hF4, 3'd7, 2'd1, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hF4, 4'h0};
    vecs[8]  = '{8'h4B, 3'd1, 2'd3, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hF4, 4'hB};
    vecs[9]  = '{8'h18, 3'd1, 2'd0, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hF4, 4'h0};
    vecs[10] = '{8'h02, 3'd0, 2'd0, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hF4, 4'h0};
    vecs[11] = '{8'h08, 3'd1, 2'd3, 14'h1800, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hF4, 4'h0};
    vecs[12] = '{8'h20, 3'd1, 2'd2, 14'h1800, 14'h2000, 14'h2000, 14'h3F80, 14'h2800, 8'hF4, 4'h4};
    vecs[13] = '{8'hFF, 3'd2, 2'd2, 14'h3C00, 14'h2000, 14'h2000, 14'h3F80, 14'h2800, 8'hF4, 4'h4};

    // Reset state
    do_reset();
    check("rst.mode", 32'(mode), 32'h1);
    check("rst.video_on", 32'(video_on), 32'h0);
    check("rst.tables", 32'(name_addr | color_addr | font_addr | sattr_addr | spat_addr), 32'h0);
    check("rst.n_int", 32'(n_int), 32'h1);
    check("rst.cpu_dout", 32'(cpu_dout), 32'h0);
    check("rst.strobes", 32'({vram_wr, vram_rd}), 32'h0);
    check("rst.vram_addr", 32'(vram_addr), 32'h0);

    // Register table
    for (int i = 0; i < NV; i++) begin
      op(1'b1, 1'b1, vecs[i].val);
      op(1'b1, 1'b1, {5'b10000, vecs[i].idx});
      check($sformatf("vec%0d.mode", i), 32'(mode), 32'(vecs[i].exp_mode));
      check($sformatf("vec%0d.name", i), 32'(name_addr), 32'(vecs[i].exp_name));
      check($sformatf("vec%0d.color", i), 32'(color_addr), 32'(vecs[i].exp_color));
      check($sformatf("vec%0d.font", i), 32'(font_addr), 32'(vecs[i].exp_font));
      check($sformatf("vec%0d.sattr", i), 32'(sattr_addr), 32'(vecs[i].exp_sattr));
      check($sformatf("vec%0d.spat", i), 32'(spat_addr), 32'(vecs[i].exp_spat));
      check($sformatf("vec%0d.colors", i), 32'({text_color, back_color}),
            32'(vecs[i].exp_colors));
      check($sformatf("vec%0d.ctl", i),
            32'({video_on, vert_retrace_int, sprite_large, sprite_enlarged}),
            32'(vecs[i].exp_ctl));
    end

    // Data write at top of VRAM, address wrap
    do_reset();
    op(1'b1, 1'b1, 8'hFF);
    op(1'b1, 1'b1, 8'h7F);
    check("wrap.addr_set", 32'(vram_addr), 32'h3FFF);
    strobe(1'b0, 1'b1, 8'hAA);
    check("wrap.vram_wr", 32'(vram_wr), 32'h1);
    check("wrap.old_addr", 32'(vram_addr), 32'h3FFF);
    check("wrap.vram_dout", 32'(vram_dout), 32'hAA);
    @(negedge clk);
    check("wrap.wr_pulse", 32'(vram_wr), 32'h0);
    check("wrap.new_addr", 32'(vram_addr), 32'h0000);
    repeat (2) @(negedge clk);
    check("wrap.mem", 32'(mem[14'h3FFF]), 32'hAA);

    // Fill 0x0100..0x0101, then read back through the prefetch path
    op(1'b1, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h41);
    op(1'b0, 1'b1, 8'h11);
    op(1'b0, 1'b1, 8'h22);
    check("fill.addr", 32'(vram_addr), 32'h0102);
    op(1'b1, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h01);
    check("rd.prefetch_addr", 32'(vram_addr), 32'h0101);
    op(1'b0, 1'b0, 8'h00);
    check("rd.first", 32'(cpu_dout), 32'h11);
    strobe(1'b0, 1'b0, 8'h00);
    check("rd.second", 32'(cpu_dout), 32'h22);
    check("rd.addr", 32'(vram_addr), 32'h0102);
    check("rd.vram_rd", 32'(vram_rd), 32'h1);
    repeat (3) @(negedge clk);

    // Interrupt and status flags
    do_reset();
    op(1'b1, 1'b1, 8'h20);
    op(1'b1, 1'b1, 8'h81);
    check("irq.idle", 32'(n_int), 32'h1);
    @(negedge clk);
    interrupt_flag = 1'b1;
    @(negedge clk);
    interrupt_flag = 1'b0;
    @(negedge clk);
    check("irq.assert", 32'(n_int), 32'(IrqLow));
    op(1'b1, 1'b0, 8'h00);
    check("irq.status1", 32'(cpu_dout), 32'h80);
    check("irq.cleared", 32'(n_int), 32'h1);
    op(1'b1, 1'b0, 8'h00);
    check("irq.status2", 32'(cpu_dout), 32'h00);

    sprite5 = 5'h0A;
    @(negedge clk);
    too_many_sprites = 1'b1;
    @(negedge clk);
    too_many_sprites = 1'b0;
    sprite5 = 5'h03;
    @(negedge clk);
    op(1'b1, 1'b0, 8'h00);
    check("s5.status", 32'(cpu_dout), 32'h4A);
    op(1'b1, 1'b0, 8'h00);
    check("s5.cleared", 32'(cpu_dout), 32'h03);
    @(negedge clk);
    sprite_collision = 1'b1;
    @(negedge clk);
    sprite_collision = 1'b0;
    op(1'b1, 1'b0, 8'h00);
    check("coll.status", 32'(cpu_dout), 32'h23);

    // Flag set coincident with a status-read clear: the set survives
    @(negedge clk);
    cpu_port = 1'b1;
    cpu_rd = 1'b1;
    interrupt_flag = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    interrupt_flag = 1'b0;
    check("setwin.read", 32'(cpu_dout), 32'h03);
    check("setwin.n_int", 32'(n_int), 32'(IrqLow));
    repeat (3) @(negedge clk);
    op(1'b1, 1'b0, 8'h00);
    check("setwin.status", 32'(cpu_dout), 32'h83);

    // Status read resets the control-port byte toggle
    do_reset();
    op(1'b1, 1'b1, 8'h12);
    op(1'b1, 1'b0, 8'h00);
    op(1'b1, 1'b1, 8'h34);
    op(1'b1, 1'b1, 8'h40);
    check("toggle.addr", 32'(vram_addr), 32'h0034);

    // Reset during a prefetch aborts it with no capture
    do_reset();
    op(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h05);
    check("abort.vram_rd", 32'(vram_rd), 32'h1);
    check("abort.addr", 32'(vram_addr), 32'h0500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.rd_off", 32'(vram_rd), 32'h0);
    repeat (3) @(negedge clk);
    check("abort.no_capture", 32'(vram_addr), 32'h0000);
    op(1'b0, 1'b0, 8'h00);
    check("abort.read_buf", 32'(cpu_dout), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
